// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and datapath-select encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/mc_imm_dec.sv
// rtl/mc_imm_dec.sv - immediate-format decode from opcode
// Ports: op (7-bit opcode) -> imm_src (3-bit immediate format select).
module mc_imm_dec
    import mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// rtl/mc_main_fsm.sv - multicycle RISC-V main controller FSM
// Ports: clk, resetn (async active-low); op, funct3, zero, mem_ready in;
// pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a,
// alu_src_b, alu_op, imm_src, instr_done, state (debug) out.
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic [3:0] state
);

    state_t cur_state, nxt_state;
    logic   pc_w, ir_w, mem_w, reg_w, done_w;
    logic   br_taken;

    // Only beq/bne are decoded; other funct3 values never redirect the PC.
    assign br_taken = ((funct3 == 3'b000) || (funct3 == 3'b001)) && (zero ^ funct3[0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur_state <= S_FETCH;
        else         cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state  = cur_state;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        done_w     = 1'b0;
        adr_src    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        case (cur_state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_w       = mem_ready;
                ir_w       = mem_ready;
                if (mem_ready) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: nxt_state = S_MEMADR;
                    OP_RTYPE:          nxt_state = S_EXECUTER;
                    OP_ITYPE:          nxt_state = S_EXECUTEI;
                    OP_BRANCH:         nxt_state = S_BRANCH;
                    OP_JAL:            nxt_state = S_JAL;
                    default:           nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                nxt_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) nxt_state = S_MEMWB;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = mem_ready;
                done_w  = mem_ready;
                if (mem_ready) nxt_state = S_FETCH;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
                done_w     = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_FUNCT;
                nxt_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w     = 1'b1;
                done_w    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_SUB;
                pc_w      = br_taken;
                done_w    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_w      = 1'b1;
                nxt_state = S_ALUWB;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // The state register already reads FETCH during reset, but FETCH strobes
    // follow mem_ready, so the strobes are also masked by resetn directly.
    assign pc_write   = resetn & pc_w;
    assign ir_write   = resetn & ir_w;
    assign mem_write  = resetn & mem_w;
    assign reg_write  = resetn & reg_w;
    assign instr_done = resetn & done_w;
    assign state      = cur_state;

    mc_imm_dec u_imm_dec (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule
